snoop_controller: RTL

SNOOP_CONTROLLER -- requirements
Module: snoop_controller

---
 rtl/snoop_controller_if.sv | 38 +++
 rtl/snoop_controller.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/snoop_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : snoop_controller_if
// Brief    : Bus-side snoop request and write-back handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface snoop_controller_if #(
    parameter int IW    = 2,
    parameter int TAG_W = 8
);
    logic             snoop_valid;
    logic [1:0]       snoop_op;
    logic [IW-1:0]    snoop_index;
    logic [TAG_W-1:0] snoop_tag;
    logic             snoop_ready;
    logic             snoop_done;
    logic             snoop_hit;
    logic             write_back;
    logic             abort_memory_access;
    logic [IW-1:0]    wb_index;
    logic [TAG_W-1:0] wb_tag;
    logic             wb_ack;

    // Bus / memory side
    modport master (
        output snoop_valid, snoop_op, snoop_index, snoop_tag, wb_ack,
        input  snoop_ready, snoop_done, snoop_hit,
        input  write_back, abort_memory_access, wb_index, wb_tag
    );

    // Snoop controller side
    modport slave (
        input  snoop_valid, snoop_op, snoop_index, snoop_tag, wb_ack,
        output snoop_ready, snoop_done, snoop_hit,
        output write_back, abort_memory_access, wb_index, wb_tag
    );
endinterface
`default_nettype wire

// File: rtl/snoop_controller.sv
`default_nettype none
// ============================================================================
// Module   : snoop_controller
// Brief    : MSI/MESI bus snoop controller with per-line state/tag array,
//            Modified-line write-back handshake and processor-side updates.
// Revision : 1.0 - initial release
// ============================================================================
module snoop_controller #(
    parameter int   LINES = 4,
    parameter int   TAG_W = 8,
    parameter int   MESI  = 0,
    localparam int  IW    = (LINES > 1) ? $clog2(LINES) : 1
) (
    input  wire logic             clock,
    input  wire logic             reset,
    snoop_controller_if.slave     bus,
    input  wire logic             local_wr_en,
    input  wire logic [IW-1:0]    local_index,
    input  wire logic [TAG_W-1:0] local_tag,
    input  wire logic [1:0]       local_state,
    output logic                  local_retry,
    output logic                  protocol_error,
    output logic [2*LINES-1:0]    line_states
);

    localparam logic [1:0] C_ST_I = 2'b00;
    localparam logic [1:0] C_ST_S = 2'b01;
    localparam logic [1:0] C_ST_M = 2'b10;
    localparam logic [1:0] C_ST_E = 2'b11;

    localparam logic [1:0] C_OP_NONE = 2'b00;
    localparam logic [1:0] C_OP_RD   = 2'b01;
    localparam logic [1:0] C_OP_INV  = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        WRITEBACK = 2'd2
    } fsm_t;

    fsm_t             r_fsm;
    logic [1:0]       r_op;
    logic [IW-1:0]    r_index;
    logic [TAG_W-1:0] r_tag;
    logic             r_done;
    logic             r_hit;
    logic             r_perr;
    logic             r_wb;
    logic [1:0]       r_line_state [LINES];
    logic [TAG_W-1:0] r_line_tag   [LINES];

    logic             w_hit;
    logic             w_conflict;
    logic [1:0]       w_local_state;
    logic [1:0]       w_cur_state;
    logic [1:0]       w_snoop_next;

    assign w_cur_state  = r_line_state[r_index];
    assign w_hit        = (w_cur_state != C_ST_I) && (r_line_tag[r_index] == r_tag);
    assign w_snoop_next = (r_op == C_OP_RD) ? C_ST_S : C_ST_I;

    // A processor write may not race the snoop on the line under service.
    assign w_conflict    = local_wr_en && (r_fsm != IDLE) && (local_index == r_index);
    assign w_local_state = ((MESI == 0) && (local_state == C_ST_E)) ? C_ST_S : local_state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fsm   <= IDLE;
            r_op    <= C_OP_NONE;
            r_index <= '0;
            r_tag   <= '0;
            r_done  <= 1'b0;
            r_hit   <= 1'b0;
            r_perr  <= 1'b0;
            r_wb    <= 1'b0;
            for (int i = 0; i < LINES; i++) begin
                r_line_state[i] <= C_ST_I;
                r_line_tag[i]   <= '0;
            end
        end else begin
            r_done <= 1'b0;
            r_hit  <= 1'b0;
            r_perr <= 1'b0;

            if (local_wr_en && !w_conflict) begin
                r_line_state[local_index] <= w_local_state;
                r_line_tag[local_index]   <= local_tag;
            end

            case (r_fsm)
                IDLE: begin
                    if (bus.snoop_valid && (bus.snoop_op != C_OP_NONE)) begin
                        r_op    <= bus.snoop_op;
                        r_index <= bus.snoop_index;
                        r_tag   <= bus.snoop_tag;
                        r_fsm   <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    r_fsm  <= IDLE;
                    r_done <= 1'b1;
                    r_hit  <= w_hit;
                    if (w_hit) begin
                        case (w_cur_state)
                            C_ST_S, C_ST_E: r_line_state[r_index] <= w_snoop_next;
                            C_ST_M: begin
                                if (r_op == C_OP_INV) begin
                                    r_line_state[r_index] <= C_ST_I;
                                    r_perr                <= 1'b1;
                                end else begin
                                    // Completion is deferred until memory takes the dirty line.
                                    r_fsm  <= WRITEBACK;
                                    r_done <= 1'b0;
                                    r_hit  <= 1'b0;
                                    r_wb   <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                WRITEBACK: begin
                    if (bus.wb_ack) begin
                        r_line_state[r_index] <= w_snoop_next;
                        r_wb   <= 1'b0;
                        r_done <= 1'b1;
                        r_hit  <= 1'b1;
                        r_fsm  <= IDLE;
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

    assign bus.snoop_ready         = (r_fsm == IDLE);
    assign bus.snoop_done          = r_done;
    assign bus.snoop_hit           = r_hit;
    assign bus.write_back          = r_wb;
    assign bus.abort_memory_access = r_wb;
    assign bus.wb_index            = r_index;
    assign bus.wb_tag              = r_tag;
    assign local_retry             = w_conflict;
    assign protocol_error          = r_perr;

    for (genvar g = 0; g < LINES; g++) begin : g_line_states
        assign line_states[2*g+1:2*g] = r_line_state[g];
    end

endmodule
`default_nettype wire
